// File: rtl/cory_sram_ro_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : cory_sram_ro_pipe_if
// Purpose  : Request, SRAM and return-data bundle for cory_sram_ro_pipe.
//            The slave modport is the pipe's own view of the signals.
//            The master modport is the view of whatever surrounds it.
// Revision : 1.0 - initial release
// ============================================================================
interface cory_sram_ro_pipe_if #(
  parameter int C = 2,
  parameter int A = 8,
  parameter int D = 8
);
  logic [C-1:0] i_s_cen;
  logic [A-1:0] i_s_addr;
  logic         o_s_r;
  logic [C-1:0] o_z_cen;
  logic [C-1:0] o_z_oen;
  logic [A-1:0] o_z_addr;
  logic [D-1:0] i_z_rdata;
  logic         i_z_r;
  logic         o_d_v;
  logic [D-1:0] o_d_d;
  logic         i_d_r;

  modport slave (
    input  i_s_cen, i_s_addr, i_z_rdata, i_z_r, i_d_r,
    output o_s_r, o_z_cen, o_z_oen, o_z_addr, o_d_v, o_d_d
  );

  modport master (
    output i_s_cen, i_s_addr, i_z_rdata, i_z_r, i_d_r,
    input  o_s_r, o_z_cen, o_z_oen, o_z_addr, o_d_v, o_d_d
  );
endinterface
`default_nettype wire

// File: rtl/cory_sram_ro_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cory_sram_ro_pipe
// Purpose  : Read-only SRAM front end.
//            It issues requests to a fixed-latency SRAM and carries
//            valid/cen through an L-stage pipe to drive the output enables.
//            Returned words are queued in a Q-entry FIFO.
//            Credits (inflight + occupancy < Q) guarantee the FIFO never
//            overflows.
// Options  : CORY_SRAM_RO_PIPE_STAT_EN - enables the saturating stall counter
//            on o_stall_cnt (tied to zero otherwise).
//            SIM - enables a simulation-only overflow trap.
// Revision : 1.0 - initial release
// ============================================================================
module cory_sram_ro_pipe #(
  parameter int C = 2,
  parameter int A = 8,
  parameter int D = 8,
  parameter int L = 1,
  parameter int Q = 4
) (
  input  wire                   clk,
  input  wire                   reset,
  cory_sram_ro_pipe_if.slave    bus,
  output logic [15:0]           o_stall_cnt
);

  // Counter width must hold L+Q; pointer width covers Q entries.
  localparam int c_cnt_w = $clog2(L + Q + 1);
  localparam int c_ptr_w = $clog2(Q);

  logic                 w_s_v;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic [c_cnt_w-1:0]   w_sum;

  logic [L-1:0]         r_pv;
  logic [C-1:0]         r_pcen [L];
  logic [c_cnt_w-1:0]   r_inflight;
  logic [c_cnt_w-1:0]   r_occ;
  logic [D-1:0]         r_mem [Q];
  logic [c_ptr_w-1:0]   r_wp;
  logic [c_ptr_w-1:0]   r_rp;

  // Request handshake: credits come from registered counts only, so a pop
  // frees its slot one cycle later.
  assign w_s_v        = ~(&bus.i_s_cen);
  assign w_sum        = r_inflight + r_occ;
  assign bus.o_s_r    = ~reset & w_s_v & bus.i_z_r & (w_sum < c_cnt_w'(Q));
  assign w_accept     = bus.o_s_r;
  assign bus.o_z_cen  = bus.o_s_r ? bus.i_s_cen : {C{1'b1}};
  assign bus.o_z_addr = bus.i_s_addr;

  // The last pipe stage marks the cycle the SRAM drives its data.
  assign bus.o_z_oen  = (~reset & r_pv[L-1]) ? r_pcen[L-1] : {C{1'b1}};
  assign w_push       = ~reset & r_pv[L-1];

  // Return side: head of the FIFO is presented directly.
  assign bus.o_d_v    = ~reset & (r_occ != '0);
  assign bus.o_d_d    = r_mem[r_rp];
  assign w_pop        = bus.o_d_v & bus.i_d_r;

  // Valid shift pipe; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pv <= '0;
    end else begin
      r_pv[0] <= w_accept;
      for (int k = 1; k < L; k++) r_pv[k] <= r_pv[k-1];
    end
  end

  // Chip-enable shift pipe, qualified by r_pv so it needs no reset.
  always_ff @(posedge clk) begin
    r_pcen[0] <= bus.i_s_cen;
    for (int k = 1; k < L; k++) r_pcen[k] <= r_pcen[k-1];
  end

  // Inflight and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= '0;
      r_occ      <= '0;
    end else begin
      r_inflight <= r_inflight + c_cnt_w'(w_accept) - c_cnt_w'(r_pv[L-1]);
      r_occ      <= r_occ + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end
  end

  // FIFO pointers with wrap at Q (Q need not be a power of two).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= (r_wp == c_ptr_w'(Q - 1)) ? '0 : r_wp + 1'b1;
      if (w_pop)  r_rp <= (r_rp == c_ptr_w'(Q - 1)) ? '0 : r_rp + 1'b1;
    end
  end

  // FIFO storage captures the SRAM word in the cycle its oen is active.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= bus.i_z_rdata;
  end

`ifdef SIM
  // Overflow trap: the credit scheme should make this unreachable.
  always_ff @(posedge clk) begin
    if (w_push && (r_occ == c_cnt_w'(Q))) begin
      $display("ERROR: cory_sram_ro_pipe push into full FIFO");
      $finish;
    end
  end
`endif

`ifdef CORY_SRAM_RO_PIPE_STAT_EN
  logic [15:0] r_stall_cnt;

  // Count cycles where a request is presented but not accepted; saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_s_v && !bus.o_s_r && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cory_sram_ro_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cory_sram_ro_pipe
// Purpose  : Directed self-checking bench for cory_sram_ro_pipe (L=2, Q=4).
//            The SRAM model returns addr ^ 0xA5 two cycles after the
//            address is presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cory_sram_ro_pipe;

  logic        clk;
  logic        reset;
  logic [15:0] stall;
  logic [7:0]  r_a1;
  logic [7:0]  r_a2;
  int          n_assert;
  int          n_fail;
  int          n_acc;

  cory_sram_ro_pipe_if #(.C(2), .A(8), .D(8)) bus ();

  cory_sram_ro_pipe #(.C(2), .A(8), .D(8), .L(2), .Q(4)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_stall_cnt (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model with two cycles of read latency.
  always_ff @(posedge clk) begin
    r_a1 <= bus.o_z_addr;
    r_a2 <= r_a1;
  end
  assign bus.i_z_rdata = r_a2 ^ 8'hA5;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.i_s_cen  = 2'b11;
    bus.i_s_addr = 8'h00;
    bus.i_z_r    = 1'b1;
    bus.i_d_r    = 1'b1;

    // Reset state, with a request presented
    cyc(); reset = 1'b1; bus.i_s_cen = 2'b10;
    mid();
    chk("rst_s_r",  32'(bus.o_s_r),   32'h0);
    chk("rst_d_v",  32'(bus.o_d_v),   32'h0);
    chk("rst_zcen", 32'(bus.o_z_cen), 32'h3);
    chk("rst_zoen", 32'(bus.o_z_oen), 32'h3);
    cyc();
    mid();
    chk("rst_stall", 32'(stall), 32'h0);
    cyc(); reset = 1'b0; bus.i_s_cen = 2'b11;
    mid();
    chk("post_rst_d_v", 32'(bus.o_d_v), 32'h0);

    // Single read of 0x10
    cyc(); bus.i_s_cen = 2'b10; bus.i_s_addr = 8'h10;
    mid();
    chk("t1_s_r",  32'(bus.o_s_r),    32'h1);
    chk("t1_zcen", 32'(bus.o_z_cen),  32'h2);
    chk("t1_zadr", 32'(bus.o_z_addr), 32'h10);
    cyc(); bus.i_s_cen = 2'b11;
    mid();
    chk("t1_oen_c1", 32'(bus.o_z_oen), 32'h3);
    cyc();
    mid();
    chk("t1_oen_c2", 32'(bus.o_z_oen), 32'h2);
    chk("t1_dv_c2",  32'(bus.o_d_v),   32'h0);
    cyc();
    mid();
    chk("t1_dv_c3", 32'(bus.o_d_v), 32'h1);
    chk("t1_dd_c3", 32'(bus.o_d_d), 32'hB5);
    cyc();
    mid();
    chk("t1_dv_c4", 32'(bus.o_d_v), 32'h0);

    // Eight back-to-back reads, data beats three cycles behind
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (c < 8) begin
        bus.i_s_cen = 2'b01; bus.i_s_addr = 8'(8'h20 + c);
      end else begin
        bus.i_s_cen = 2'b11;
      end
      mid();
      if (c < 8) chk("t2_s_r", 32'(bus.o_s_r), 32'h1);
      if (c >= 3 && c <= 10) begin
        chk("t2_d_v", 32'(bus.o_d_v), 32'h1);
        chk("t2_d_d", 32'(bus.o_d_d), 32'((8'h20 + 8'(c - 3)) ^ 8'hA5));
      end
    end
    chk("t2_d_v_end", 32'(bus.o_d_v), 32'h0);

    // Backpressure: only Q reads are accepted, the head word stays stable
    bus.i_d_r = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(); bus.i_s_cen = 2'b10; bus.i_s_addr = 8'(8'h40 + n_acc);
      mid();
      if (bus.o_s_r) n_acc++;
      if (bus.o_d_v) chk("t3_hold_dd", 32'(bus.o_d_d), 32'hE5);
    end
    chk("t3_n_acc",  32'(n_acc),     32'd4);
    chk("t3_s_r_lo", 32'(bus.o_s_r), 32'h0);
    cyc(); bus.i_d_r = 1'b1; bus.i_s_addr = 8'h44;
    mid();
    chk("t3_pop_s_r", 32'(bus.o_s_r), 32'h0);
    chk("t3_dd0",     32'(bus.o_d_d), 32'hE5);
    cyc();
    mid();
    chk("t3_credit_s_r", 32'(bus.o_s_r), 32'h1);
    chk("t3_dd1",        32'(bus.o_d_d), 32'hE4);
    cyc(); bus.i_s_cen = 2'b11;
    mid();
    chk("t3_dd2", 32'(bus.o_d_d), 32'hE7);
    cyc();
    mid();
    chk("t3_dd3", 32'(bus.o_d_d), 32'hE6);
    cyc();
    mid();
    chk("t3_dv4", 32'(bus.o_d_v), 32'h1);
    chk("t3_dd4", 32'(bus.o_d_d), 32'hE1);
    cyc();
    mid();
    chk("t3_dv_end", 32'(bus.o_d_v), 32'h0);

    // SRAM stall for three cycles
    cyc(); reset = 1'b1;
    mid();
    cyc(); reset = 1'b0;
    mid();
    for (int c = 0; c < 3; c++) begin
      cyc(); bus.i_z_r = 1'b0; bus.i_s_cen = 2'b10;
      mid();
      chk("t4_zcen", 32'(bus.o_z_cen), 32'h3);
      chk("t4_s_r",  32'(bus.o_s_r),   32'h0);
    end
    cyc(); bus.i_z_r = 1'b1; bus.i_s_cen = 2'b11;
    mid();
`ifdef CORY_SRAM_RO_PIPE_STAT_EN
    chk("t4_stall", 32'(stall), 32'd3);
`else
    chk("t4_stall", 32'(stall), 32'd0);
`endif

    // Reset with two reads in the pipe
    cyc(); bus.i_s_cen = 2'b01; bus.i_s_addr = 8'h60;
    mid();
    chk("t5_s_r0", 32'(bus.o_s_r), 32'h1);
    cyc(); bus.i_s_addr = 8'h61;
    mid();
    chk("t5_s_r1", 32'(bus.o_s_r), 32'h1);
    cyc(); bus.i_s_cen = 2'b11; reset = 1'b1;
    mid();
    chk("t5_rst_oen", 32'(bus.o_z_oen), 32'h3);
    chk("t5_rst_dv",  32'(bus.o_d_v),   32'h0);
    for (int c = 0; c < 5; c++) begin
      cyc(); reset = 1'b0;
      mid();
      chk("t5_dv_after", 32'(bus.o_d_v), 32'h0);
    end

`ifdef CORY_SRAM_RO_PIPE_STAT_EN
    // Stall counter saturation
    bus.i_z_r = 1'b0; bus.i_s_cen = 2'b10;
    repeat (70000) cyc();
    mid();
    chk("t6_sat", 32'(stall), 32'hFFFF);
    bus.i_z_r = 1'b1; bus.i_s_cen = 2'b11;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cory_sram_ro_pipe.md
CORY_SRAM_RO_PIPE -- requirements
Module: cory_sram_ro_pipe

Interface
REQ-001 SHALL have parameter C, default 2: number of SRAM chip-enable/output-enable bits.
REQ-002 SHALL have parameter A, default 8: address width.
REQ-003 SHALL have parameter D, default 8: read-data width.
REQ-004 SHALL have parameter L, default 1: SRAM read latency in cycles, legal range 1..4.
REQ-005 SHALL have parameter Q, default 4: return-queue depth and outstanding-read credit limit, legal range 2..16.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port i_s_cen, input, C: request chip-enables, active-low; the request is valid when any bit is 0.
REQ-009 SHALL have port i_s_addr, input, A: request address.
REQ-010 SHALL have port o_s_r, output, 1: request ready.
REQ-011 SHALL have port o_z_cen, input-facing output, C: SRAM chip-enables.
REQ-012 SHALL have port o_z_oen, output, C: SRAM output-enables.
REQ-013 SHALL have port o_z_addr, output, A: SRAM address.
REQ-014 SHALL have port i_z_rdata, input, D: SRAM read data.
REQ-015 SHALL have port i_z_r, input, 1: SRAM ready; the SRAM accepts a request only when this is 1.
REQ-016 SHALL have port o_d_v, output, 1: return data valid.
REQ-017 SHALL have port o_d_d, output, D: return data.
REQ-018 SHALL have port i_d_r, input, 1: return data ready.
REQ-019 SHALL have port o_stall_cnt, output, 16: stall statistic (see Configuration).

Function
REQ-020 SHALL define s_v = (&i_s_cen == 0) and accept = s_v & o_s_r.
REQ-021 SHALL drive o_s_r = s_v & i_z_r & (inflight + occ < Q), using registered counts only; a pop in the same cycle does not free a credit until the next cycle.
REQ-022 SHALL drive o_z_cen = i_s_cen when o_s_r=1, otherwise all-ones; o_z_addr = i_s_addr always.
REQ-023 SHALL carry a valid bit plus the issued cen through an L-stage shift pipe; o_z_oen SHALL equal the issued cen during cycle t+L for a request accepted in cycle t, and all-ones otherwise.
REQ-024 SHALL capture i_z_rdata at the end of cycle t+L into a Q-entry FIFO; the earliest o_d_v is in cycle t+L+1.
REQ-025 SHALL keep inflight (0..L) = pipe stages holding valid entries, and occ (0..Q) = FIFO occupancy.
REQ-026 SHALL pop the FIFO on o_d_v & i_d_r; simultaneous push and pop leaves occ unchanged.
REQ-027 SHALL return data strictly in request order; o_d_d SHALL remain stable while o_d_v=1 and i_d_r=0.
REQ-028 SHALL never push into a full FIFO; the credit rule guarantees this, and under SIM the block SHALL $display ERROR and $finish on violation.
REQ-029 SHALL sustain one read per cycle when Q >= L+2 and i_d_r=1 is held.
REQ-030 SHALL size the inflight/occ adders to hold L+Q without overflow.

Reset
REQ-031 SHALL, with reset=1 at a clock edge, clear the pipe valids, inflight, occ, FIFO pointers and o_stall_cnt.
REQ-032 SHALL hold o_s_r=0, o_d_v=0, o_z_cen=all-ones and o_z_oen=all-ones while reset=1.
REQ-033 SHALL discard reads in flight when reset occurs mid-operation; data returning after reset is never queued.

Configuration
REQ-034 SHALL, with macro CORY_SRAM_RO_PIPE_STAT_EN defined, increment o_stall_cnt each cycle where s_v=1 and o_s_r=0, saturating at 0xFFFF.
REQ-035 SHALL, without CORY_SRAM_RO_PIPE_STAT_EN, tie o_stall_cnt to 0 and include no counter logic.

Verification (L=2, Q=4 unless noted)
REQ-036 Single read: addr 0x10 accepted in cycle 0 with i_d_r=1 -> o_z_oen active in cycle 2; o_d_v=1 with the SRAM word in cycle 3.
REQ-037 Back-to-back: 8 reads with i_d_r=1 and Q=4 -> o_s_r stays 1, and 8 data beats appear in order on consecutive cycles.
REQ-038 Backpressure: i_d_r=0 while issuing -> exactly 4 reads accepted, then o_s_r=0; after i_d_r is raised, o_s_r returns to 1 one cycle after the first pop.
REQ-039 SRAM stall: i_z_r=0 for 3 cycles with s_v=1 -> o_z_cen all-ones and o_s_r=0; with STAT_EN defined, o_stall_cnt=3.
REQ-040 Reset mid-flight: reset asserted with 2 reads in the pipe -> o_d_v never rises for them and occ=0 after reset.
REQ-041 Saturation: STAT_EN defined and 70000 stall cycles -> o_stall_cnt=0xFFFF.
